// File: rtl/dec_freelist_pkg.sv
// -----------------------------------------------------------------------------
// dec_freelist_pkg
// Shared sizing for the rename-stage physical register free list.
//   PRF_NUM / ARF_NUM     : physical / architectural register counts
//   PRF_CODE_WIDTH        : width of a physical register code
//   ARF_CODE_WIDTH        : width of an architectural register index
//   FL_DEPTH              : free list capacity (PRF_NUM - ARF_NUM), power of two
//   PTR_W / CNT_W         : ring pointer width / occupancy counter width
//   LANES                 : rename and commit width
// -----------------------------------------------------------------------------
package dec_freelist_pkg;

  localparam int PRF_NUM        = 64;
  localparam int ARF_NUM        = 32;
  localparam int PRF_CODE_WIDTH = $clog2(PRF_NUM);
  localparam int ARF_CODE_WIDTH = $clog2(ARF_NUM);
  localparam int FL_DEPTH       = PRF_NUM - ARF_NUM;
  localparam int PTR_W          = $clog2(FL_DEPTH);
  localparam int CNT_W          = PTR_W + 1;
  localparam int LANES          = 4;

  typedef logic [PRF_CODE_WIDTH-1:0] prf_code_t;
  typedef logic [ARF_CODE_WIDTH-1:0] arf_code_t;
  typedef logic [PTR_W-1:0]          fl_ptr_t;
  typedef logic [CNT_W-1:0]          fl_cnt_t;

  // Ring index arithmetic: FL_DEPTH is a power of two, so truncation to
  // PTR_W bits is exactly the modulo-FL_DEPTH wrap.
  function automatic fl_ptr_t fl_ptr_add(fl_ptr_t base, logic [2:0] delta);
    return base + fl_ptr_t'(delta);
  endfunction

endpackage

// File: rtl/dec_fl_prefix.sv
// -----------------------------------------------------------------------------
// dec_fl_prefix
// Compacts a 4-lane request mask: each lane gets the number of requesting
// lanes below it, so requesters map onto consecutive ring slots.
//   i_req   : per-lane request mask
//   o_off   : per-lane offset (count of set bits below lane k)
//   o_total : popcount of i_req (0..4)
// -----------------------------------------------------------------------------
module dec_fl_prefix
  import dec_freelist_pkg::*;
(
  input  logic [LANES-1:0]      i_req,
  output logic [LANES-1:0][1:0] o_off,
  output logic [2:0]            o_total
);

  logic [2:0] acc;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch or
    // loop so no path leaves it unassigned (which would infer a latch).
    acc   = '0;
    o_off = '0;
    // NOTE: blocking '=' here is intentional: acc is a running sum that each
    // loop iteration must see updated immediately.
    for (int k = 0; k < LANES; k++) begin
      o_off[k] = acc[1:0];
      acc      = acc + 3'(i_req[k]);
    end
    o_total = acc;
  end

endmodule

// File: rtl/dec_freelist.sv
// -----------------------------------------------------------------------------
// dec_freelist
// Physical register free list feeding the 4-wide rename table. A ring of
// FL_DEPTH PRF codes: rename pops compacted codes at rd_ptr (zero-latency
// read), commit pushes returned codes at wr_ptr, and an exception flush
// reclaims every speculative allocation by rewinding rd_ptr.
//   clk, rst                       : clock, synchronous active-high reset
//   i_fl_alloc_req_0..3            : lane k needs a new destination PRF
//   i_fl_alloc_en                  : rename advances; allocation consumed
//   o_fl_alloc_prf_code_0..3       : new PRF code for lane k (0 if no request)
//   o_fl_alloc_rdy                 : enough free entries for all requests
//   i_fl_free_en_0..3              : commit lane k returns a PRF
//   i_fl_free_prf_code_0..3        : returned PRF code
//   i_fl_except_flush              : restore the non-speculative free list
//   o_fl_free_cnt                  : current number of free entries
// -----------------------------------------------------------------------------
module dec_freelist
  import dec_freelist_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_fl_alloc_req_0,
  input  logic                      i_fl_alloc_req_1,
  input  logic                      i_fl_alloc_req_2,
  input  logic                      i_fl_alloc_req_3,
  input  logic                      i_fl_alloc_en,
  output logic [PRF_CODE_WIDTH-1:0] o_fl_alloc_prf_code_0,
  output logic [PRF_CODE_WIDTH-1:0] o_fl_alloc_prf_code_1,
  output logic [PRF_CODE_WIDTH-1:0] o_fl_alloc_prf_code_2,
  output logic [PRF_CODE_WIDTH-1:0] o_fl_alloc_prf_code_3,
  output logic                      o_fl_alloc_rdy,
  input  logic                      i_fl_free_en_0,
  input  logic                      i_fl_free_en_1,
  input  logic                      i_fl_free_en_2,
  input  logic                      i_fl_free_en_3,
  input  logic [PRF_CODE_WIDTH-1:0] i_fl_free_prf_code_0,
  input  logic [PRF_CODE_WIDTH-1:0] i_fl_free_prf_code_1,
  input  logic [PRF_CODE_WIDTH-1:0] i_fl_free_prf_code_2,
  input  logic [PRF_CODE_WIDTH-1:0] i_fl_free_prf_code_3,
  input  logic                      i_fl_except_flush,
  output logic [CNT_W-1:0]          o_fl_free_cnt
);

  logic [LANES-1:0]        alloc_req;
  logic [LANES-1:0]        free_en;
  prf_code_t [LANES-1:0]   free_code;
  prf_code_t [LANES-1:0]   alloc_code;

  logic [LANES-1:0][1:0]   alloc_off;
  logic [LANES-1:0][1:0]   free_off;
  logic [2:0]              n_alloc;
  logic [2:0]              n_free;

  prf_code_t               mem_q [FL_DEPTH];
  prf_code_t               mem_d [FL_DEPTH];
  logic [FL_DEPTH-1:0]     mem_we;

  fl_ptr_t                 rd_ptr_q, rd_ptr_d;
  fl_ptr_t                 wr_ptr_q, wr_ptr_d;
  fl_cnt_t                 cnt_q, cnt_d;
  fl_cnt_t                 spec_cnt_q, spec_cnt_d;
  fl_cnt_t                 spec_after_free;

  logic                    alloc_rdy;
  logic                    alloc_fire;

  assign alloc_req = {i_fl_alloc_req_3, i_fl_alloc_req_2,
                      i_fl_alloc_req_1, i_fl_alloc_req_0};
  assign free_en   = {i_fl_free_en_3, i_fl_free_en_2,
                      i_fl_free_en_1, i_fl_free_en_0};
  assign free_code = {i_fl_free_prf_code_3, i_fl_free_prf_code_2,
                      i_fl_free_prf_code_1, i_fl_free_prf_code_0};

  dec_fl_prefix u_alloc_prefix (
    .i_req   (alloc_req),
    .o_off   (alloc_off),
    .o_total (n_alloc)
  );

  dec_fl_prefix u_free_prefix (
    .i_req   (free_en),
    .o_off   (free_off),
    .o_total (n_free)
  );

  // Ready looks only at the registered count: same-cycle frees are not
  // bypassed, they become allocatable after the edge.
  assign alloc_rdy  = cnt_q >= fl_cnt_t'(n_alloc);
  assign alloc_fire = i_fl_alloc_en & alloc_rdy & ~i_fl_except_flush;

  // Zero-latency compacted read of the ring head.
  always_comb begin
    alloc_code = '0;
    for (int k = 0; k < LANES; k++) begin
      if (alloc_req[k]) begin
        alloc_code[k] = mem_q[fl_ptr_add(rd_ptr_q, {1'b0, alloc_off[k]})];
      end
    end
  end

  assign o_fl_alloc_prf_code_0 = alloc_code[0];
  assign o_fl_alloc_prf_code_1 = alloc_code[1];
  assign o_fl_alloc_prf_code_2 = alloc_code[2];
  assign o_fl_alloc_prf_code_3 = alloc_code[3];
  assign o_fl_alloc_rdy        = alloc_rdy;
  assign o_fl_free_cnt         = cnt_q;

  // Compacted write of returned codes at the ring tail; offsets are
  // distinct, so at most one lane targets any entry.
  always_comb begin
    mem_we = '0;
    for (int i = 0; i < FL_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    for (int k = 0; k < LANES; k++) begin
      if (free_en[k]) begin
        mem_we[fl_ptr_add(wr_ptr_q, {1'b0, free_off[k]})] = 1'b1;
        mem_d[fl_ptr_add(wr_ptr_q, {1'b0, free_off[k]})]  = free_code[k];
      end
    end
  end

  // Frees are older than a same-cycle flush, so they are folded in first;
  // the flush then rewinds rd_ptr over whatever is still speculative, which
  // lands it exactly on the new wr_ptr (ring full again).
  always_comb begin
    spec_after_free = spec_cnt_q - fl_cnt_t'(n_free);
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = fl_ptr_add(wr_ptr_q, n_free);
    cnt_d           = cnt_q + fl_cnt_t'(n_free);
    spec_cnt_d      = spec_after_free;
    if (i_fl_except_flush) begin
      rd_ptr_d   = rd_ptr_q - spec_after_free[PTR_W-1:0];
      cnt_d      = fl_cnt_t'(FL_DEPTH);
      spec_cnt_d = '0;
    end else if (alloc_fire) begin
      rd_ptr_d   = fl_ptr_add(rd_ptr_q, n_alloc);
      cnt_d      = cnt_d - fl_cnt_t'(n_alloc);
      spec_cnt_d = spec_cnt_d + fl_cnt_t'(n_alloc);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples its
  // _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= fl_cnt_t'(FL_DEPTH);
      spec_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      spec_cnt_q <= spec_cnt_d;
    end
  end

  // Per-entry enabled flops.
  // NOTE: this storage is reset on purpose: after reset the ring must hold
  // the non-architectural codes ARF_NUM..PRF_NUM-1, so it is built from
  // resettable flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FL_DEPTH; i++) begin
      if (rst) begin
        mem_q[i] <= prf_code_t'(ARF_NUM + i);
      end else if (mem_we[i]) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Illegal-use checks: returning more codes than are outstanding, or
  // returning p0 (permanently mapped to x0).
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ({1'b0, cnt_q} + 7'(n_free) <= 7'(FL_DEPTH));
      for (int k = 0; k < LANES; k++) begin
        assert (!(free_en[k] && (free_code[k] == '0)));
      end
    end
  end

endmodule

// File: tb/tb_dec_freelist.sv
module tb_dec_freelist;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic             en;
  logic             flush;
  logic [3:0]       fen;
  logic [3:0][5:0]  fcode;
  logic [5:0]       code_0, code_1, code_2, code_3;
  logic             rdy;
  logic [5:0]       cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dec_freelist u_dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_fl_alloc_req_0      (req[0]),
    .i_fl_alloc_req_1      (req[1]),
    .i_fl_alloc_req_2      (req[2]),
    .i_fl_alloc_req_3      (req[3]),
    .i_fl_alloc_en         (en),
    .o_fl_alloc_prf_code_0 (code_0),
    .o_fl_alloc_prf_code_1 (code_1),
    .o_fl_alloc_prf_code_2 (code_2),
    .o_fl_alloc_prf_code_3 (code_3),
    .o_fl_alloc_rdy        (rdy),
    .i_fl_free_en_0        (fen[0]),
    .i_fl_free_en_1        (fen[1]),
    .i_fl_free_en_2        (fen[2]),
    .i_fl_free_en_3        (fen[3]),
    .i_fl_free_prf_code_0  (fcode[0]),
    .i_fl_free_prf_code_1  (fcode[1]),
    .i_fl_free_prf_code_2  (fcode[2]),
    .i_fl_free_prf_code_3  (fcode[3]),
    .i_fl_except_flush     (flush),
    .o_fl_free_cnt         (cnt)
  );

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic       flush;
    int         exp_cnt;
    int         exp_rdy;
    int         exp_code [4];
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(logic [3:0] r, logic e, logic f, int c, int y,
                              int c0, int c1, int c2, int c3);
    vec_t v;
    v.req = r; v.en = e; v.flush = f; v.exp_cnt = c; v.exp_rdy = y;
    v.exp_code[0] = c0; v.exp_code[1] = c1;
    v.exp_code[2] = c2; v.exp_code[3] = c3;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane_code(int k);
    case (k)
      0:       return int'(code_0);
      1:       return int'(code_1);
      2:       return int'(code_2);
      default: return int'(code_3);
    endcase
  endfunction

  task automatic check_outs(input string tag, input int e_cnt, input int e_rdy,
                            input int e0, input int e1, input int e2, input int e3);
    check({tag, " cnt"}, int'(cnt), e_cnt);
    check({tag, " rdy"}, int'(rdy), e_rdy);
    check({tag, " lane0"}, int'(code_0), e0);
    check({tag, " lane1"}, int'(code_1), e1);
    check({tag, " lane2"}, int'(code_2), e2);
    check({tag, " lane3"}, int'(code_3), e3);
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic e,
                       input logic f, input logic [3:0] fe,
                       input logic [3:0][5:0] fc);
    rst = r; req = rq; en = e; flush = f; fen = fe; fcode = fc;
  endtask

  // Inputs change just after a falling edge; outputs are sampled #1 later.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b0, 1'b0, 1'b0, 4'b0, '0);
    cycle();
    rst = 1'b0;
  endtask

  task automatic alloc4(input int n);
    drive(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0, '0);
    repeat (n) cycle();
  endtask

  // Reference model: ordered queue of free codes, and the queue of codes
  // handed out but not yet retired (oldest first).
  int free_q [$];
  int infl_q [$];

  task automatic model_reset();
    free_q.delete();
    infl_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive(1'b1, 4'b0, 1'b0, 1'b0, 4'b0, '0);
    @(negedge clk);

    // ---------------- table-driven sequence from reset ----------------
    tbl[0] = mk(4'b1111, 1'b1, 1'b0, 32, 1, 32, 33, 34, 35);
    tbl[1] = mk(4'b1111, 1'b0, 1'b0, 28, 1, 36, 37, 38, 39);
    tbl[2] = mk(4'b0000, 1'b0, 1'b1, 28, 1, 0, 0, 0, 0);
    tbl[3] = mk(4'b0101, 1'b1, 1'b0, 32, 1, 32, 0, 33, 0);
    tbl[4] = mk(4'b0000, 1'b0, 1'b0, 30, 1, 0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, tbl[i].req, tbl[i].en, tbl[i].flush, 4'b0, '0);
      #1;
      check_outs($sformatf("tbl[%0d]", i), tbl[i].exp_cnt, tbl[i].exp_rdy,
                 tbl[i].exp_code[0], tbl[i].exp_code[1],
                 tbl[i].exp_code[2], tbl[i].exp_code[3]);
      cycle();
    end

    // ---------------- empty list / stall / no free bypass ----------------
    do_reset();
    drive(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0, '0);
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("drain lane0 c%0d", c), int'(code_0), 32 + 4 * c);
      cycle();
    end
    drive(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0, '0);
    #1;
    check("empty cnt", int'(cnt), 0);
    check("empty rdy req1", int'(rdy), 0);
    cycle();
    check("stall ignored cnt", int'(cnt), 0);
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0, '0);
    #1;
    check("empty rdy no req", int'(rdy), 1);
    drive(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0011, {6'd0, 6'd0, 6'd9, 6'd5});
    #1;
    check("no free bypass rdy", int'(rdy), 0);
    cycle();
    drive(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0, '0);
    #1;
    check_outs("after free", 2, 1, 5, 0, 0, 0);
    cycle();
    #1;
    check_outs("second freed", 1, 1, 9, 0, 0, 0);

    // ---------------- wrap across index 31 -> 0 ----------------
    do_reset();
    alloc4(8);
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 4'b0, 1'b0, 1'b0, 4'b1111,
            {6'(4*c+4), 6'(4*c+3), 6'(4*c+2), 6'(4*c+1)});
      cycle();
    end
    drive(1'b0, 4'b0, 1'b0, 1'b0, 4'b0011, {6'd0, 6'd0, 6'd30, 6'd29});
    cycle();
    alloc4(7);
    drive(1'b0, 4'b0011, 1'b1, 1'b0, 4'b0, '0);
    cycle();
    drive(1'b0, 4'b0, 1'b0, 1'b0, 4'b0111, {6'd0, 6'd42, 6'd41, 6'd40});
    #1;
    check("wrap pre cnt", int'(cnt), 0);
    cycle();
    drive(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0, '0);
    #1;
    check("wrap rdy 4 of 3", int'(rdy), 0);
    drive(1'b0, 4'b0111, 1'b1, 1'b0, 4'b0, '0);
    #1;
    check_outs("wrap alloc", 3, 1, 40, 41, 42, 0);
    cycle();
    #1;
    check("wrap post cnt", int'(cnt), 0);

    // ---------------- flush with same-cycle frees ----------------
    do_reset();
    alloc4(3);
    drive(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, {6'd53, 6'd52, 6'd51, 6'd50});
    #1;
    check("flush pre cnt", int'(cnt), 20);
    cycle();
    drive(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0, '0);
    #1;
    check_outs("after flush", 32, 1, 36, 37, 38, 39);

    // ---------------- reset beats flush and alloc ----------------
    do_reset();
    alloc4(2);
    drive(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0, '0);
    cycle();
    drive(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0, '0);
    #1;
    check_outs("mid reset", 32, 1, 32, 0, 0, 0);

    // ---------------- randomized against the queue model ----------------
    do_reset();
    model_reset();
    for (int t = 0; t < 3000; t++) begin
      logic [3:0] r_req, r_fen;
      logic       r_en, r_fl, fire;
      logic [3:0][5:0] r_fc;
      int n_req, off, nf_max;

      r_req = 4'($urandom);
      r_en  = ($urandom_range(0, 3) != 0);
      r_fl  = ($urandom_range(0, 40) == 0);
      r_fen = 4'($urandom & $urandom);
      nf_max = (infl_q.size() < 4) ? infl_q.size() : 4;
      for (int k = 3; k >= 0; k--) begin
        if ($countones(r_fen) > nf_max) r_fen[k] = 1'b0;
      end
      for (int k = 0; k < 4; k++) r_fc[k] = 6'($urandom_range(1, 63));

      drive(1'b0, r_req, r_en, r_fl, r_fen, r_fc);
      #1;
      n_req = $countones(r_req);
      check($sformatf("rnd%0d cnt", t), int'(cnt), free_q.size());
      check($sformatf("rnd%0d rdy", t), int'(rdy), int'(free_q.size() >= n_req));
      off = 0;
      for (int k = 0; k < 4; k++) begin
        if (!r_req[k]) begin
          check($sformatf("rnd%0d lane%0d idle", t, k), lane_code(k), 0);
        end else begin
          if (off < free_q.size())
            check($sformatf("rnd%0d lane%0d", t, k), lane_code(k), free_q[off]);
          off++;
        end
      end
      fire = r_en && (free_q.size() >= n_req) && !r_fl;
      cycle();

      for (int k = 0; k < 4; k++) begin
        if (r_fen[k]) begin
          void'(infl_q.pop_front());
          free_q.push_back(int'(r_fc[k]));
        end
      end
      if (r_fl) begin
        for (int i = infl_q.size() - 1; i >= 0; i--) free_q.push_front(infl_q[i]);
        infl_q.delete();
      end else if (fire) begin
        for (int i = 0; i < n_req; i++) infl_q.push_back(free_q.pop_front());
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
